// File: rtl/ex_compute_unit.sv
// Registered execute-stage compute slice: ALU, branch decision and PC+imm
// adder, all results captured into output flops one cycle after operands.
module ex_compute_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [3:0]  alu_operation_type,
    input  logic        comparison_mode,
    input  logic [6:0]  control_flags,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic [31:0] alu_result,
    output logic [2:0]  comparison_flags,
    output logic        should_branch,
    output logic [31:0] pc_imm
);

    logic [31:0] alu_result_d, alu_result_q;
    logic [2:0]  comparison_flags_d, comparison_flags_q;
    logic        should_branch_d, should_branch_q;
    logic [31:0] pc_imm_d, pc_imm_q;

    logic [31:0] alu_res;
    logic [4:0]  shamt;
    logic        eq, lt_s, lt_u, lt, gt, take;
    logic        unused_cf;

    assign unused_cf = ^control_flags[1:0];
    assign shamt     = alu_b[4:0];
    assign eq        = (alu_a == alu_b);
    assign lt_s      = ($signed(alu_a) < $signed(alu_b));
    assign lt_u      = (alu_a < alu_b);
    assign lt        = comparison_mode ? lt_s : lt_u;
    assign gt        = !lt && !eq;

    assign take = control_flags[6]
                | (control_flags[5] & eq)
                | (control_flags[4] & !eq)
                | (control_flags[3] & lt)
                | (control_flags[2] & !lt);

    always_comb begin
        alu_res = 32'h0;
        case (alu_operation_type)
            4'b0000: alu_res = alu_a + alu_b;
            4'b1000: alu_res = alu_a - alu_b;
            4'b0001: alu_res = alu_a << shamt;
            4'b0010: alu_res = {31'h0, lt_s};
            4'b0011: alu_res = {31'h0, lt_u};
            4'b0100: alu_res = alu_a ^ alu_b;
            4'b0101: alu_res = alu_a >> shamt;
            4'b1101: alu_res = $unsigned($signed(alu_a) >>> shamt);
            4'b0110: alu_res = alu_a | alu_b;
            4'b0111: alu_res = alu_a & alu_b;
            default: alu_res = 32'h0;
        endcase
    end

    always_comb begin
        alu_result_d       = alu_result_q;
        comparison_flags_d = comparison_flags_q;
        should_branch_d    = should_branch_q;
        pc_imm_d           = pc_imm_q;
        if (enable) begin
            alu_result_d       = alu_res;
            comparison_flags_d = {lt, gt, eq};
            should_branch_d    = take;
            pc_imm_d           = pc + imm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_q       <= 32'h0;
            comparison_flags_q <= 3'b000;
            should_branch_q    <= 1'b0;
            pc_imm_q           <= 32'h0;
        end else begin
            alu_result_q       <= alu_result_d;
            comparison_flags_q <= comparison_flags_d;
            should_branch_q    <= should_branch_d;
            pc_imm_q           <= pc_imm_d;
        end
    end

    assign alu_result       = alu_result_q;
    assign comparison_flags = comparison_flags_q;
    assign should_branch    = should_branch_q;
    assign pc_imm           = pc_imm_q;

endmodule

// File: tb/tb_ex_compute_unit.sv
// Directed scoreboard bench for ex_compute_unit.
module tb_ex_compute_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] alu_a, alu_b, pc, imm;
    logic [3:0]  alu_operation_type;
    logic        comparison_mode;
    logic [6:0]  control_flags;
    logic [31:0] alu_result, pc_imm;
    logic [2:0]  comparison_flags;
    logic        should_branch;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        logic        br;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    ex_compute_unit dut (
        .clk(clk), .reset(reset), .enable(enable),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_operation_type(alu_operation_type),
        .comparison_mode(comparison_mode),
        .control_flags(control_flags),
        .pc(pc), .imm(imm),
        .alu_result(alu_result),
        .comparison_flags(comparison_flags),
        .should_branch(should_branch),
        .pc_imm(pc_imm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".res"}, alu_result, e.res);
        chk({tag, ".flg"}, {29'h0, comparison_flags}, {29'h0, e.flg});
        chk({tag, ".br"}, {31'h0, should_branch}, {31'h0, e.br});
        chk({tag, ".tgt"}, pc_imm, e.tgt);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic m,
                         input logic [6:0] cf);
        alu_operation_type = op;
        alu_a = a;
        alu_b = b;
        comparison_mode = m;
        control_flags = cf;
    endtask

    // push expectation, let the edge capture, then pop and compare
    task automatic issue(input string tag, input logic [31:0] r,
                         input logic [2:0] f, input logic br,
                         input logic [31:0] t);
        exp_t e, got;
        e.res = r; e.flg = f; e.br = br; e.tgt = t;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            got = sb.pop_front();
            check_all(tag, got);
        end
    endtask

    exp_t zero;

    initial begin
        zero.res = 32'h0; zero.flg = 3'b000; zero.br = 1'b0; zero.tgt = 32'h0;
        reset = 1'b1;
        enable = 1'b1;
        pc = 32'h0;
        imm = 32'h0;
        drive(4'b0000, 32'h0, 32'h0, 1'b0, 7'h0);
        #2;
        check_all("reset", zero);
        @(posedge clk);
        #1;
        check_all("reset_held", zero);
        @(negedge clk);
        reset = 1'b0;

        pc = 32'h100; imm = 32'hFFFFFFF0;
        drive(4'b0000, 32'hFFFFFFFF, 32'h1, 1'b1, 7'h0);
        issue("add_wrap", 32'h0, 3'b100, 1'b0, 32'hF0);

        pc = 32'h0; imm = 32'h0;
        drive(4'b1000, 32'h0, 32'h1, 1'b0, 7'h0);
        issue("sub_wrap", 32'hFFFFFFFF, 3'b100, 1'b0, 32'h0);

        drive(4'b0101, 32'h80000000, 32'h24, 1'b0, 7'h0);
        issue("srl", 32'h08000000, 3'b010, 1'b0, 32'h0);

        drive(4'b1101, 32'h80000000, 32'h24, 1'b1, 7'h0);
        issue("sra", 32'hF8000000, 3'b100, 1'b0, 32'h0);

        drive(4'b0001, 32'h1, 32'h24, 1'b0, 7'h0);
        issue("sll", 32'h10, 3'b100, 1'b0, 32'h0);

        drive(4'b0010, 32'hFFFFFFFF, 32'h1, 1'b1, 7'h0);
        issue("slt", 32'h1, 3'b100, 1'b0, 32'h0);

        drive(4'b0011, 32'hFFFFFFFF, 32'h1, 1'b0, 7'h0);
        issue("sltu", 32'h0, 3'b010, 1'b0, 32'h0);

        drive(4'b0000, 32'h5, 32'h5, 1'b1, 7'h20);
        issue("beq", 32'hA, 3'b001, 1'b1, 32'h0);

        drive(4'b0000, 32'h5, 32'h5, 1'b1, 7'h10);
        issue("bne", 32'hA, 3'b001, 1'b0, 32'h0);

        drive(4'b0100, 32'h3, 32'h7, 1'b1, 7'h04);
        issue("bge", 32'h4, 3'b100, 1'b0, 32'h0);

        drive(4'b0110, 32'h3, 32'h7, 1'b1, 7'h08);
        issue("blt", 32'h7, 3'b100, 1'b1, 32'h0);

        drive(4'b0111, 32'h1, 32'h2, 1'b1, 7'h40);
        issue("jump", 32'h0, 3'b100, 1'b1, 32'h0);

        drive(4'b1111, 32'h5, 32'h5, 1'b0, 7'h03);
        issue("nobr", 32'h0, 3'b001, 1'b0, 32'h0);

        pc = 32'hFFFFFFFF; imm = 32'h2;
        drive(4'b1000, 32'hFFFFFFFF, 32'h1, 1'b0, 7'h04);
        issue("bgeu", 32'hFFFFFFFE, 3'b010, 1'b1, 32'h1);

        enable = 1'b0;
        pc = 32'h40; imm = 32'h4;
        drive(4'b0000, 32'h1, 32'h1, 1'b1, 7'h40);
        issue("hold", 32'hFFFFFFFE, 3'b010, 1'b1, 32'h1);
        enable = 1'b1;

        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all("async_rst", zero);
        @(posedge clk);
        #1;
        check_all("rst_no_pulse", zero);
        @(negedge clk);
        reset = 1'b0;

        pc = 32'h1000; imm = 32'h8;
        drive(4'b0000, 32'h2, 32'h3, 1'b0, 7'h08);
        issue("after_rst", 32'h5, 3'b100, 1'b1, 32'h1008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
